lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Serial receive-side counterpart of the 8-bit button-stepped LFSR pattern generator on the nvboard examples.
- Accepts the generator's shifted-out bit stream (generator state bit 0, one bit per step) and self-synchronises by loading 8 received bits as the generator state.
- Once locked, it predicts every following bit, flags and counts mismatches, and drops lock on excessive errors.
- Sits between a bit source (the generator or the board switches/buttons) and LED/status display logic.

Parameters:
- TAP_MASK, 8'b0001_1101, feedback taps; fb = XOR of reg bits where the mask bit is 1 (default taps 4,3,2,0).
- LOSS_THRESH, 4, errors within one window that force loss of lock (1..LOSS_WINDOW).
- LOSS_WINDOW, 32, checked bits per error-accounting window.
- CNT_W, 16, width of err_cnt.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- bit_valid  in  1  bit_in is sampled on this clock edge; one bit per asserted cycle.
- bit_in  in  1  received serial bit (the generator's state bit 0 before each step).
- cnt_clr  in  1  synchronous clear of err_cnt and loss_cnt.
- locked  out  1  high while in CHECK state.
- err_pulse  out  1  one-cycle pulse: last checked bit mismatched.
- err_cnt  out  CNT_W  saturating count of mismatches while locked.
- loss_cnt  out  8  saturating count of CHECK->HUNT transitions.

Behaviour:
- Reset (asynchronous): state=HUNT, shreg=0, fill=0, win_bits=0, win_errs=0; locked=0, err_pulse=0, err_cnt=0, loss_cnt=0.
- Cycles with bit_valid=0 change nothing except err_pulse<=0 and cnt_clr.
- HUNT:
  - On each valid bit: shreg <= {bit_in, shreg[7:1]}; fill increments, saturating at 8.
  - Lock when fill reaches 8 (counting the current bit) and the new shreg != 0: go to CHECK; locked rises the cycle after the 8th valid bit.
  - If the new shreg == 0 (illegal generator state): stay in HUNT; each later valid bit re-evaluates the sliding 8-bit window.
- CHECK:
  - expected = ^(shreg & TAP_MASK).
  - On a valid bit: shreg <= {expected, shreg[7:1]}. The generator is free-running, so received errors do not corrupt the prediction.
  - On a mismatch: err_pulse=1 next cycle; err_cnt+1 (saturates at all-ones); win_errs+1.
  - win_bits counts checked bits. When it reaches LOSS_WINDOW, win_bits=0 and win_errs=0 on that same edge, after evaluating the current bit.
  - If win_errs (including the current bit) reaches LOSS_THRESH: go to HUNT; fill=0, win_bits=0, win_errs=0; loss_cnt+1 (saturates at 255); locked falls next cycle.
  - shreg is kept on loss of lock but fill=0, so 8 fresh bits are required to relock.
- cnt_clr has priority over increments in the same cycle; the coinciding error still pulses err_pulse and still counts toward win_errs.
- Reset mid-operation returns to the reset state immediately, regardless of clock.
- Latency: all outputs are registered, one cycle after the valid bit.

Optional Feature:
- LFSR_CHECKER_LED_EN:
  - When defined, adds output ledr[15:0] = {locked, err_pulse_stretch, 6'b0, shreg}. err_pulse_stretch holds high for 2^20 clk cycles after any error, so errors are visible on the board.
  - Without the macro, the port and the stretch counter do not exist.

Decomposition:
- Shared package lfsr_pkg:
  - state enum {HUNT, CHECK};
  - LFSR_W=8;
  - default TAP_MASK constant, shared with the generator;
  - function lfsr_fb(state, mask).
- One natural sub-module: lfsr_win_monitor, containing win_bits, win_errs and threshold compare, with output loss_req.

Test Plan:
- Generator from state 0x01 emits 1,0,0,0,0,0,0,0 -> after the 8th valid bit, locked=1 next cycle and shreg=0x01; the 9th bit 1 (generator state 0x71) -> no err_pulse, err_cnt=0.
- Lock on 0x01 as above, then feed 0 as the 9th bit -> err_pulse for exactly 1 cycle, err_cnt=1, locked stays 1; the following correct bits give no further errors.
- Feed 8 zeros -> locked stays 0; then feed 1 -> locked=1 (window 0x80 nonzero).
- Locked stream, inject 4 errors within 32 bits -> locked=0 after the 4th error, loss_cnt=1. Inject 3 errors in window 1 and 1 error in window 2 -> stays locked.
- cnt_clr asserted on the same cycle as a mismatch with err_cnt=5 -> err_cnt=0, err_pulse=1.
- Assert reset between clock edges while locked -> all outputs 0 immediately; 8 valid bits needed before relock.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the 8-bit LFSR pattern generator and its receive-side checker.
// Revision: 1.0
`default_nettype none

package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Taps 4,3,2,0; the generator and the checker must agree on this value.
    localparam logic [LFSR_W-1:0] DEFAULT_TAP_MASK = 8'b0001_1101;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } lfsr_state_t;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] state,
                                     input logic [LFSR_W-1:0] mask);
        return ^(state & mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_win_monitor.sv
// lfsr_win_monitor: counts checked bits and errors per window; requests loss of lock at threshold.
// Revision: 1.0
`default_nettype none

module lfsr_win_monitor #(
    parameter int LOSS_THRESH = 4,
    parameter int LOSS_WINDOW = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic err,
    output logic loss_req
);

    localparam int BW = $clog2(LOSS_WINDOW + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(LOSS_WINDOW - 1);
    localparam logic [EW-1:0] THRESH   = EW'(LOSS_THRESH);

    logic [BW-1:0] win_bits;
    logic [EW-1:0] win_errs;
    logic [EW-1:0] errs_next;

    // Error count including the bit being checked this cycle.
    always_comb begin
        errs_next = win_errs + EW'(err);
        loss_req  = step && (errs_next >= THRESH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_bits <= '0;
            win_errs <= '0;
        end else if (step) begin
            if (loss_req || (win_bits == LAST_BIT)) begin
                win_bits <= '0;
                win_errs <= '0;
            end else begin
                win_bits <= win_bits + 1'b1;
                win_errs <= errs_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the serial output of the 8-bit LFSR generator.
// Optional macro LFSR_CHECKER_LED_EN adds the ledr[15:0] board display output.
// Revision: 1.0
`default_nettype none

module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAP_MASK    = DEFAULT_TAP_MASK,
    parameter int                LOSS_THRESH = 4,
    parameter int                LOSS_WINDOW = 32,
    parameter int                CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             cnt_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       loss_cnt
`ifdef LFSR_CHECKER_LED_EN
    ,
    output logic [15:0]      ledr
`endif
);

    localparam logic [3:0] FILL_LAST = 4'd7;
    localparam logic [3:0] FILL_FULL = 4'd8;

    lfsr_state_t       state;
    logic [LFSR_W-1:0] shreg;
    logic [3:0]        fill;

    logic              expected;
    logic              mismatch;
    logic              step;
    logic              loss_req;
    logic [LFSR_W-1:0] hunt_shreg;

    always_comb begin
        expected   = lfsr_fb(shreg, TAP_MASK);
        mismatch   = bit_in ^ expected;
        step       = bit_valid && (state == CHECK);
        hunt_shreg = {bit_in, shreg[LFSR_W-1:1]};
    end

    lfsr_win_monitor #(
        .LOSS_THRESH(LOSS_THRESH),
        .LOSS_WINDOW(LOSS_WINDOW)
    ) u_win_monitor (
        .clk     (clk),
        .reset   (reset),
        .step    (step),
        .err     (mismatch),
        .loss_req(loss_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            shreg     <= '0;
            fill      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            loss_cnt  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (cnt_clr) begin
                err_cnt  <= '0;
                loss_cnt <= '0;
            end
            if (bit_valid) begin
                case (state)
                    HUNT: begin
                        shreg <= hunt_shreg;
                        if (fill != FILL_FULL) begin
                            fill <= fill + 1'b1;
                        end
                        // An all-zero window is not a legal generator state; keep sliding.
                        if ((fill >= FILL_LAST) && (hunt_shreg != '0)) begin
                            state  <= CHECK;
                            locked <= 1'b1;
                        end
                    end
                    CHECK: begin
                        // Prediction follows the free-running generator, not the received bit.
                        shreg <= {expected, shreg[LFSR_W-1:1]};
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (!cnt_clr && (err_cnt != '1)) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                        if (loss_req) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                            fill   <= '0;
                            if (!cnt_clr && (loss_cnt != '1)) begin
                                loss_cnt <= loss_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        fill   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_CHECKER_LED_EN
    localparam int STRETCH_W = 20;

    logic [STRETCH_W-1:0] stretch_cnt;
    logic                 err_pulse_stretch;

    // The pulse cycle plus 2^20-1 countdown cycles keeps the LED lit for 2^20 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stretch_cnt <= '0;
        end else if (err_pulse) begin
            stretch_cnt <= '1;
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - 1'b1;
        end
    end

    assign err_pulse_stretch = err_pulse || (stretch_cnt != '0);
    assign ledr              = {locked, err_pulse_stretch, 6'b0, shreg};
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed vector table plus hand-written sequences for lfsr_checker.
// Revision: 1.0
`default_nettype none

module tb_lfsr_checker;

    logic        clk;
    logic        reset;
    logic        bit_valid;
    logic        bit_in;
    logic        cnt_clr;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [7:0]  loss_cnt;
`ifdef LFSR_CHECKER_LED_EN
    logic [15:0] ledr;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] g;

    lfsr_checker dut (
        .clk      (clk),
        .reset    (reset),
        .bit_valid(bit_valid),
        .bit_in   (bit_in),
        .cnt_clr  (cnt_clr),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .loss_cnt (loss_cnt)
`ifdef LFSR_CHECKER_LED_EN
        ,
        .ledr     (ledr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        din;
        logic        clr;
        logic        exp_locked;
        logic        exp_pulse;
        logic [15:0] exp_err_cnt;
        logic [7:0]  exp_loss_cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    // Reference generator: taps 4,3,2,0, shifting right, emitting bit 0.
    function automatic logic [7:0] gen_next(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        cnt_clr   = c;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic send_gen(input logic flip, input logic clr);
        step(1'b1, g[0] ^ flip, clr);
        g = gen_next(g);
    endtask

    task automatic check_outs(input string tag, input logic l, input logic p,
                              input int unsigned ec, input int unsigned lc);
        check({tag, " locked"}, locked, l);
        check({tag, " err_pulse"}, err_pulse, p);
        check({tag, " err_cnt"}, err_cnt, ec);
        check({tag, " loss_cnt"}, loss_cnt, lc);
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        cnt_clr   = 1'b0;

        // Generator from 0x01 emits 1,0,0,0,0,0,0,0, then 1,0,0,0,1,1 (states 0x71..0x23).
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 8'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 8'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 8'd0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'd0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'd0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 8'd0};

        #2;
        check_outs("reset", 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].valid, vecs[i].din, vecs[i].clr);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_locked, vecs[i].exp_pulse,
                       vecs[i].exp_err_cnt, vecs[i].exp_loss_cnt);
        end

        // Checker now expects the bit of generator state 14; window holds 6 bits, 1 error.
        g = 8'h01;
        repeat (14) g = gen_next(g);
        send_gen(1'b1, 1'b0);
        check_outs("loss e1", 1'b1, 1'b1, 1, 0);
        send_gen(1'b1, 1'b0);
        check_outs("loss e2", 1'b1, 1'b1, 2, 0);
        send_gen(1'b1, 1'b0);
        check_outs("loss e3", 1'b0, 1'b1, 3, 1);

        for (int i = 0; i < 7; i++) begin
            send_gen(1'b0, 1'b0);
            check($sformatf("relock bit%0d locked", i), locked, 1'b0);
        end
        send_gen(1'b0, 1'b0);
        check_outs("relock", 1'b1, 1'b0, 3, 1);

        // Three errors in a fresh window, one in the next: must stay locked.
        for (int i = 0; i < 32; i++) begin
            send_gen((i == 0) || (i == 10) || (i == 20), 1'b0);
        end
        check_outs("window1 end", 1'b1, 1'b0, 6, 1);
        send_gen(1'b1, 1'b0);
        check_outs("window2 err", 1'b1, 1'b1, 7, 1);
        send_gen(1'b0, 1'b0);
        check_outs("window2 ok", 1'b1, 1'b0, 7, 1);

        send_gen(1'b1, 1'b1);
        check_outs("clr+err", 1'b1, 1'b1, 0, 0);
        send_gen(1'b1, 1'b0);
        check_outs("err after clr", 1'b1, 1'b1, 1, 0);

        // Asynchronous reset between edges while locked with err_pulse high.
        #2;
        reset = 1'b1;
        #1;
        check_outs("async reset", 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("zeros bit%0d locked", i), locked, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0);
        check_outs("zeros then one", 1'b1, 1'b0, 0, 0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_gen(1'b0, 1'b0);
            check($sformatf("post-reset bit%0d locked", i), locked, 1'b0);
        end
        send_gen(1'b0, 1'b0);
        check("post-reset lock", locked, 1'b1);
        send_gen(1'b0, 1'b0);
        check_outs("post-reset track", 1'b1, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
